// File: rtl/j1_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// j1_ram_arbiter_if
//   Bundles the three buses that meet at the j1 RAM arbiter:
//     cpu_*  : CPU RAM port (address, request, write strobe/data, read data,
//              pause back to the CPU)
//     host_* : loader/debugger port (request/ack handshake, read/write,
//              address, data, halt)
//     ram_*  : the single-port RAM (address, write enable/data, sync read data)
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (CPU, host and RAM together)
// ---------------------------------------------------------------------------
interface j1_ram_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic [AW-1:0] cpu_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_pause;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wd;
  logic          host_halt;
  logic          host_ack;
  logic [DW-1:0] host_rd;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;

  modport slave (
    input  cpu_addr, cpu_req, cpu_we, cpu_wd,
    input  host_req, host_we, host_addr, host_wd, host_halt,
    input  ram_rd,
    output cpu_rd, cpu_pause, host_ack, host_rd,
    output ram_addr, ram_we, ram_wd
  );

  modport master (
    output cpu_addr, cpu_req, cpu_we, cpu_wd,
    output host_req, host_we, host_addr, host_wd, host_halt,
    output ram_rd,
    input  cpu_rd, cpu_pause, host_ack, host_rd,
    input  ram_addr, ram_we, ram_wd
  );
endinterface

// File: rtl/j1_ram_arbiter.sv
// ---------------------------------------------------------------------------
// j1_ram_arbiter
//   Shares the single-port j1 RAM between the CPU and a host port. The CPU
//   owns the RAM by default; a host access takes one RAM cycle (HGRANT) and
//   is acknowledged in the following cycle (HDONE). A pending host request
//   that keeps losing to the CPU is forced through after STARVE_MAX cycles.
//   host_halt keeps the CPU paused so the host gets every slot.
//   Ports:
//     clk    : clock, all state on posedge
//     resetq : asynchronous reset, active low
//     bus    : j1_ram_arbiter_if.slave (CPU, host and RAM buses)
// ---------------------------------------------------------------------------
module j1_ram_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             resetq,
  j1_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HGRANT = 2'd1,
    HDONE  = 2'd2
  } state_e;

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic          ack_q;
  logic          hwe_q;     // direction of the access in flight
  logic [DW-1:0] rd_q;      // last host read data, held between reads

  logic          host_slot;
  logic          host_grant;
  logic [AW-1:0] ram_addr_d;

  assign host_slot  = (state_q == HGRANT);
  assign host_grant = bus.host_req &
                      (bus.host_halt | ~bus.cpu_req | (starve_q == STARVE_TOP));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // races between the state, counter and data registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= IDLE;
      starve_q <= '0;
      ack_q    <= 1'b0;
      hwe_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_grant) begin
            state_q  <= HGRANT;
            starve_q <= '0;
            hwe_q    <= bus.host_we;
          end else if (bus.host_req && starve_q != STARVE_TOP) begin
            starve_q <= starve_q + SW'(1);
          end
        end
        HGRANT: begin
          state_q <= HDONE;
          ack_q   <= 1'b1;
        end
        HDONE: begin
          // host_req is ignored here; the RAM read data is valid this cycle
          state_q <= IDLE;
          if (!hwe_q) rd_q <= bus.ram_rd;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM port steering. Write enables and pause are forced low while reset is
  // asserted so an access interrupted by reset never writes the RAM.
  always_comb begin
    ram_addr_d    = host_slot ? bus.host_addr : bus.cpu_addr;
    bus.ram_addr  = ram_addr_d;
    bus.ram_wd    = host_slot ? bus.host_wd : bus.cpu_wd;
    bus.ram_we    = resetq & (host_slot ? bus.host_we : (bus.cpu_we & bus.cpu_req));
    bus.cpu_pause = resetq & (host_slot | bus.host_halt);
  end

  assign bus.cpu_rd   = bus.ram_rd;
  assign bus.host_ack = ack_q;
  // In HDONE of a read the RAM output is the fresh data; otherwise hold.
  assign bus.host_rd  = (state_q == HDONE && !hwe_q) ? bus.ram_rd : rd_q;

endmodule

// File: tb/tb_j1_ram_arbiter.sv
module tb_j1_ram_arbiter;

  logic clk    = 1'b0;
  logic resetq = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  logic [15:0] mem [512];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  j1_ram_arbiter_if #(.AW(9), .DW(16)) bus ();

  j1_ram_arbiter #(.AW(9), .DW(16), .STARVE_MAX(4)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  // Synchronous single-port RAM, 1-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected host_rd value
  initial begin
    forever begin
      @(negedge clk);
      if (resetq && bus.host_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got host_ack=1 expected no pending access");
        end else begin
          check("host_rd", {16'h0, bus.host_rd}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at posedge+1: raises a host request, optionally queueing its result
  task automatic start(input logic we, input logic [8:0] a, input logic [15:0] d,
                       input logic [15:0] exp, input bit expect_ack);
    if (expect_ack) exp_q.push_back(exp);
    bus.host_we   = we;
    bus.host_addr = a;
    bus.host_wd   = d;
    bus.host_req  = 1'b1;
  endtask

  // Waits for the ack; reports latency (negedges incl. the ack one), paused
  // cycles before the ack, pause on the first cycle, and the RAM port on the
  // cycle before the ack (the granted cycle). Ends at posedge+1 with req low.
  task automatic wait_ack(input string tag, input int exp_lat,
                          output int pause_cnt, output logic first_pause,
                          output logic [8:0] g_addr, output logic g_we,
                          output logic [15:0] g_wd);
    int lat = 0;
    bit done = 0;
    pause_cnt = 0; first_pause = 1'b0;
    g_addr = '0; g_we = 1'b0; g_wd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) first_pause = bus.cpu_pause;
      if (bus.host_ack === 1'b1) done = 1;
      else begin
        if (bus.cpu_pause) pause_cnt++;
        g_addr = bus.ram_addr;
        g_we   = bus.ram_we;
        g_wd   = bus.ram_wd;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_ack_timeout: got no host_ack expected ack within 20 cycles", tag);
    end else begin
      check({tag, "_latency"}, lat, exp_lat);
    end
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  logic [15:0] wdat [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                            16'h5555, 16'h6666, 16'h7777, 16'h8888};

  initial begin
    int          pc;
    logic        fp;
    logic [8:0]  ga;
    logic        gw;
    logic [15:0] gd;

    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    bus.cpu_addr = 9'h0; bus.cpu_wd = 16'h0; bus.host_halt = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = 9'h0; bus.host_wd = 16'h0;

    // 1: reset with both requests and a CPU write strobe
    resetq = 1'b0; bus.host_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ram_we",    bus.ram_we,    1'b0);
    check("rst_host_ack",  bus.host_ack,  1'b0);
    check("rst_cpu_pause", bus.cpu_pause, 1'b0);
    check("rst_host_rd",   bus.host_rd,   16'h0);
    bus.host_req = 1'b0;
    @(posedge clk); #1;
    resetq = 1'b1; bus.cpu_addr = 9'h055; bus.cpu_wd = 16'h1234;
    @(negedge clk);
    check("cpu_owns_we",    bus.ram_we,    1'b1);
    check("cpu_owns_addr",  bus.ram_addr,  9'h055);
    check("cpu_owns_pause", bus.cpu_pause, 1'b0);
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_req = 1'b0;

    // 2: idle CPU, host write, zero wait
    start(1'b1, 9'h010, 16'hBEEF, 16'h0000, 1'b1);
    wait_ack("t2", 3, pc, fp, ga, gw, gd);
    check("t2_pause_cycles", pc, 1);
    check("t2_grant_we",     gw, 1'b1);
    check("t2_grant_addr",   ga, 9'h010);
    check("t2_grant_wd",     gd, 16'hBEEF);

    // 3: starvation with CPU busy every cycle
    bus.cpu_req = 1'b1; bus.cpu_addr = 9'h100;
    start(1'b0, 9'h010, 16'h0, 16'hBEEF, 1'b1);
    wait_ack("t3", 7, pc, fp, ga, gw, gd);
    check("t3_pause_cycles", pc, 1);
    check("t3_grant_we",     gw, 1'b0);
    check("t3_grant_addr",   ga, 9'h010);

    // 4: CPU and host requests rise together
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 9'h1A0;
    start(1'b0, 9'h010, 16'h0, 16'hBEEF, 1'b1);
    wait_ack("t4", 7, pc, fp, ga, gw, gd);
    check("t4_first_pause",  fp, 1'b0);
    check("t4_pause_cycles", pc, 1);

    // 5: halt mode bulk load then readback, CPU requesting reads throughout
    bus.host_halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start(1'b1, 9'(i), wdat[i], 16'hBEEF, 1'b1);
      wait_ack("t5w", 3, pc, fp, ga, gw, gd);
      check("t5w_pause_cycles", pc, 2);
      check("t5w_grant_addr",   ga, 9'(i));
    end
    for (int i = 0; i < 8; i++) begin
      start(1'b0, 9'(i), 16'h0, wdat[i], 1'b1);
      wait_ack("t5r", 3, pc, fp, ga, gw, gd);
      check("t5r_pause_cycles", pc, 2);
    end
    @(negedge clk);
    check("t5_halt_idle_pause", bus.cpu_pause, 1'b1);
    @(posedge clk); #1;
    bus.host_halt = 1'b0;
    @(negedge clk);
    check("t5_unhalt_pause", bus.cpu_pause, 1'b0);
    @(posedge clk); #1;

    // 6: reset during HGRANT of a write to 9'h003 (holds 16'h4444)
    bus.cpu_req = 1'b0;
    start(1'b1, 9'h003, 16'hDEAD, 16'h0, 1'b0);
    @(posedge clk); #1;
    check("t6_grant_pause", bus.cpu_pause, 1'b1);
    check("t6_grant_we",    bus.ram_we,    1'b1);
    resetq = 1'b0;
    #1;
    check("t6_rst_we",    bus.ram_we,    1'b0);
    check("t6_rst_pause", bus.cpu_pause, 1'b0);
    check("t6_rst_ack",   bus.host_ack,  1'b0);
    bus.host_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("t6_host_rd_cleared", bus.host_rd, 16'h0);
    start(1'b0, 9'h003, 16'h0, 16'h4444, 1'b1);
    wait_ack("t6r", 3, pc, fp, ga, gw, gd);

    repeat (4) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
